// File: rtl/ped_if.sv
// Light inputs, push-button and lamp outputs shared by the pedestrian signal stage.
interface ped_if #(parameter int CNT_W = 8);
  logic             red;
  logic             yellow;
  logic             green;
  logic             ped_btn;
  logic             walk;
  logic             dont_walk;
  logic             ped_wait;
  logic             fault;
  logic [CNT_W-1:0] countdown;

  modport master (output red, yellow, green, ped_btn,
                  input  walk, dont_walk, ped_wait, countdown, fault);
  modport slave  (input  red, yellow, green, ped_btn,
                  output walk, dont_walk, ped_wait, countdown, fault);
endinterface

// File: rtl/ped_signal_controller.sv
// Pedestrian WALK / flashing DON'T WALK stage driven by the upstream light outputs,
// with a debounced push-button request and a sticky light-conflict fault.
module ped_signal_controller #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int WALK_CYCLES     = 20,
  parameter int FLASH_CYCLES    = 10,
  parameter int BLINK_HALF      = 2,
  parameter int CNT_W           = 8
) (
  input logic  clk,
  input logic  rst,
  ped_if.slave bus
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int PW = $clog2(2 * BLINK_HALF + 1);

  typedef enum logic [1:0] {IDLE, WAIT, WALK, FLASH} state_t;

  state_t           state, state_n;
  logic             sync1, sync2, req, req_n, red_q, fault, fault_n;
  logic             walk, walk_n, dont_walk, dont_walk_n;
  logic             press, red_rise, conflict, enter_walk;
  logic [DW-1:0]    deb_cnt, deb_cnt_n;
  logic [PW-1:0]    ph, ph_n;
  logic [CNT_W-1:0] cnt, cnt_n;

  // Counter saturates at DEBOUNCE_CYCLES, so a held button crosses the threshold once.
  always_comb begin
    deb_cnt_n = '0;
    if (sync2)
      deb_cnt_n = (deb_cnt == DW'(DEBOUNCE_CYCLES)) ? deb_cnt : deb_cnt + DW'(1);
  end
  assign press = sync2 && (deb_cnt == DW'(DEBOUNCE_CYCLES - 1));

  assign conflict   = (bus.red & bus.yellow) | (bus.red & bus.green) | (bus.yellow & bus.green);
  assign red_rise   = bus.red & ~red_q;
  assign enter_walk = (state == WAIT) && red_rise;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    ph_n    = ph;
    fault_n = fault | conflict;
    req_n   = press | (req & ~enter_walk);
    unique case (state)
      IDLE: if (req) state_n = WAIT;
      WAIT: if (red_rise) begin
        state_n = WALK;
        cnt_n   = CNT_W'(WALK_CYCLES);
      end
      WALK: if (!bus.red) begin
        state_n = req ? WAIT : IDLE;
        cnt_n   = '0;
      end else if (cnt == CNT_W'(1)) begin
        state_n = FLASH;
        cnt_n   = CNT_W'(FLASH_CYCLES);
        ph_n    = '0;
      end else begin
        cnt_n   = cnt - CNT_W'(1);
      end
      FLASH: if (!bus.red || cnt == CNT_W'(1)) begin
        state_n = req ? WAIT : IDLE;
        cnt_n   = '0;
      end else begin
        cnt_n   = cnt - CNT_W'(1);
        ph_n    = (ph == PW'(2 * BLINK_HALF - 1)) ? '0 : ph + PW'(1);
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
    // A conflicting light sample overrides whatever else happens on this edge.
    if (fault_n) begin
      state_n = IDLE;
      cnt_n   = '0;
      req_n   = 1'b0;
    end
    walk_n      = (state_n == WALK);
    dont_walk_n = (state_n != WALK) && !((state_n == FLASH) && (ph_n >= PW'(BLINK_HALF)));
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      deb_cnt   <= '0;
      req       <= 1'b0;
      red_q     <= 1'b1;
      fault     <= 1'b0;
      cnt       <= '0;
      ph        <= '0;
      walk      <= 1'b0;
      dont_walk <= 1'b1;
    end else begin
      state     <= state_n;
      sync1     <= bus.ped_btn;
      sync2     <= sync1;
      deb_cnt   <= deb_cnt_n;
      req       <= req_n;
      red_q     <= bus.red;
      fault     <= fault_n;
      cnt       <= cnt_n;
      ph        <= ph_n;
      walk      <= walk_n;
      dont_walk <= dont_walk_n;
    end
  end

  assign bus.walk      = walk;
  assign bus.dont_walk = dont_walk;
  assign bus.ped_wait  = req;
  assign bus.countdown = cnt;
  assign bus.fault     = fault;
endmodule
